// File: rtl/pipe_pkg.sv
// pipe_pkg: shared register-tag types and forward-select encodings for the pipeline
package pipe_pkg;
  localparam int ADDR_W = 5;
  localparam int CNT_W = 16;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  typedef logic [ADDR_W-1:0] reg_t;
  typedef struct packed {
    logic v;
    reg_t rd;
    logic rw;
    logic mr;
    reg_t rs1;
    reg_t rs2;
    logic u1;
    logic u2;
  } ex_slot_t;
  typedef struct packed {
    logic v;
    reg_t rd;
    logic rw;
    logic mr;
  } mem_slot_t;
  typedef struct packed {
    logic v;
    reg_t rd;
    logic rw;
  } wb_slot_t;
  typedef struct packed {
    logic wr;
    reg_t rd;
  } tag_t;
  function automatic logic writing(logic v, logic rw, reg_t rd);
    return v & rw & (rd != '0);
  endfunction
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: picks the youngest in-flight producer of one EX source operand
module hazard_cmp
  import pipe_pkg::*;
(
  input  reg_t       src,
  input  logic       en,
  input  tag_t       mem_tag,
  input  tag_t       wb_tag,
  output logic [1:0] fwd,
  output logic       match
);
  logic hit_mem, hit_wb;
  assign hit_mem = en & mem_tag.wr & (src == mem_tag.rd);
  assign hit_wb = en & wb_tag.wr & (src == wb_tag.rd);
  assign fwd = hit_mem ? FWD_MEM : hit_wb ? FWD_WB : FWD_RF;
  assign match = hit_mem | hit_wb;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: shadow tag pipeline producing load-use stalls, flushes, forwards and WB->ID bypass
module hazard_ctrl #(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int CNT_W = pipe_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_if_id,
  output logic              bubble_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp1,
  output logic              id_byp2,
  output logic [CNT_W-1:0]  stall_cnt
);
  import pipe_pkg::*;
  ex_slot_t ex_q;
  mem_slot_t mem_q;
  wb_slot_t wb_q;
  logic [CNT_W-1:0] cnt_q;
  logic ex_wr, mem_wr, wb_wr, load_hit, stall_i, bubble_i, match_a, match_b;
  logic [1:0] fa, fb;
  tag_t mem_tag, wb_tag;
  assign ex_wr = writing(ex_q.v, ex_q.rw, ex_q.rd);
  assign mem_wr = writing(mem_q.v, mem_q.rw, mem_q.rd);
  assign wb_wr = writing(wb_q.v, wb_q.rw, wb_q.rd);
  assign load_hit = ex_wr & ex_q.mr &
                    ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
  assign stall_i = id_valid & ~ex_branch_taken & load_hit;
  assign bubble_i = stall_i | ex_branch_taken;
  // A load still in MEM has no result yet, so it is never a forward source.
  assign mem_tag = '{wr: mem_wr & ~mem_q.mr, rd: mem_q.rd};
  assign wb_tag = '{wr: wb_wr, rd: wb_q.rd};
  hazard_cmp cmp_a (
    .src(ex_q.rs1), .en(ex_q.u1), .mem_tag(mem_tag), .wb_tag(wb_tag), .fwd(fa), .match(match_a)
  );
  hazard_cmp cmp_b (
    .src(ex_q.rs2), .en(ex_q.u2), .mem_tag(mem_tag), .wb_tag(wb_tag), .fwd(fb), .match(match_b)
  );
  assign stall = stall_i & ~rst;
  assign flush_if_id = ex_branch_taken & ~rst;
  assign bubble_ex = bubble_i & ~rst;
  assign fwd_a = (match_a & ~rst) ? fa : FWD_RF;
  assign fwd_b = (match_b & ~rst) ? fb : FWD_RF;
  assign id_byp1 = ~rst & wb_wr & id_use_rs1 & (id_rs1 == wb_q.rd);
  assign id_byp2 = ~rst & wb_wr & id_use_rs2 & (id_rs2 == wb_q.rd);
  assign stall_cnt = rst ? '0 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= (id_valid & ~bubble_i) ?
              '{v: 1'b1, rd: id_rd, rw: id_reg_write, mr: id_mem_read,
                rs1: id_rs1, rs2: id_rs2, u1: id_use_rs1, u2: id_use_rs2} : '0;
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, rw: ex_q.rw, mr: ex_q.mr};
      wb_q <= '{v: mem_q.v, rd: mem_q.rd, rw: mem_q.rw};
      cnt_q <= cnt_q + CNT_W'(stall_i & ~&cnt_q);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed instruction-stream vectors plus reset corner sequences
module tb_hazard_ctrl;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
  } in_t;
  typedef struct packed {
    logic        st;
    logic        fl;
    logic        bu;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        b1;
    logic        b2;
    logic [15:0] cnt;
  } out_t;
  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;
  localparam int NV = 34;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0, id_mem_read = 0;
  logic ex_branch_taken = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic stall, flush_if_id, bubble_ex, id_byp1, id_byp2;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  int nvec = 0, nerr = 0;
  vec_t v[NV];
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_if_id(flush_if_id),
    .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b), .id_byp1(id_byp1),
    .id_byp2(id_byp2), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  function automatic in_t ins(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic br = 1'b0);
    return '{valid: 1'b1, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, rw: rw, mr: mr, br: br};
  endfunction
  function automatic out_t ex(logic st, logic fl, logic bu, logic [1:0] fa, logic [1:0] fb,
                              logic b1, logic b2, logic [15:0] cnt);
    return '{st: st, fl: fl, bu: bu, fa: fa, fb: fb, b1: b1, b2: b2, cnt: cnt};
  endfunction
  function automatic out_t z(logic [15:0] cnt);
    return ex(0, 0, 0, 2'b00, 2'b00, 0, 0, cnt);
  endfunction
  task automatic drive(in_t x);
    id_valid = x.valid;
    id_rs1 = x.rs1;
    id_use_rs1 = x.u1;
    id_rs2 = x.rs2;
    id_use_rs2 = x.u2;
    id_rd = x.rd;
    id_reg_write = x.rw;
    id_mem_read = x.mr;
    ex_branch_taken = x.br;
  endtask
  task automatic check(string name, out_t exp);
    out_t got;
    got = '{st: stall, fl: flush_if_id, bu: bubble_ex, fa: fwd_a, fb: fwd_b,
            b1: id_byp1, b2: id_byp2, cnt: stall_cnt};
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got st=%b fl=%b bu=%b fa=%b fb=%b b1=%b b2=%b cnt=%0d, expected st=%b fl=%b bu=%b fa=%b fb=%b b1=%b b2=%b cnt=%0d",
               name, got.st, got.fl, got.bu, got.fa, got.fb, got.b1, got.b2, got.cnt,
               exp.st, exp.fl, exp.bu, exp.fa, exp.fb, exp.b1, exp.b2, exp.cnt);
    end
  endtask
  // A load sitting in MEM must never feed an EX source: the stall is what prevents it.
  always @(negedge clk) begin
    if (!rst && dut.mem_q.v && dut.mem_q.rw && dut.mem_q.mr && dut.mem_q.rd != 0 &&
        ((dut.ex_q.u1 && dut.ex_q.rs1 == dut.mem_q.rd) ||
         (dut.ex_q.u2 && dut.ex_q.rs2 == dut.mem_q.rd))) begin
      nerr++;
      $display("FAIL load_in_mem: EX source matches load rd=%0d, required no match", dut.mem_q.rd);
    end
  end
  initial begin
    v[0] = '{ins(1, 1, 0, 0, 2, 1, 1), z(0)};
    v[1] = '{ins(2, 1, 1, 1, 3, 1, 0), ex(1, 0, 1, 2'b00, 2'b00, 0, 0, 0)};
    v[2] = '{ins(2, 1, 1, 1, 3, 1, 0), z(1)};
    v[3] = '{'0, ex(0, 0, 0, 2'b01, 2'b00, 0, 0, 1)};
    v[4] = '{'0, z(1)};
    v[5] = '{'0, z(1)};
    v[6] = '{ins(0, 1, 0, 0, 5, 1, 0), z(1)};
    v[7] = '{ins(5, 1, 5, 1, 6, 1, 0), z(1)};
    v[8] = '{ins(5, 1, 6, 1, 7, 1, 0), ex(0, 0, 0, 2'b10, 2'b10, 0, 0, 1)};
    v[9] = '{'0, ex(0, 0, 0, 2'b01, 2'b10, 0, 0, 1)};
    v[10] = '{'0, z(1)};
    v[11] = '{'0, z(1)};
    v[12] = '{ins(0, 1, 0, 0, 0, 1, 0), z(1)};
    v[13] = '{ins(0, 1, 0, 1, 1, 1, 0), z(1)};
    v[14] = '{ins(0, 1, 0, 0, 0, 1, 1), z(1)};
    v[15] = '{ins(0, 1, 0, 1, 4, 1, 0), z(1)};
    v[16] = '{'0, z(1)};
    v[17] = '{'0, z(1)};
    v[18] = '{'0, z(1)};
    v[19] = '{ins(1, 1, 0, 0, 8, 1, 1), z(1)};
    v[20] = '{ins(8, 1, 8, 1, 10, 1, 0, 1), ex(0, 1, 1, 2'b00, 2'b00, 0, 0, 1)};
    v[21] = '{'0, z(1)};
    v[22] = '{ins(8, 1, 8, 1, 11, 1, 0), ex(0, 0, 0, 2'b00, 2'b00, 1, 1, 1)};
    v[23] = '{'0, z(1)};
    v[24] = '{'0, z(1)};
    v[25] = '{'0, z(1)};
    v[26] = '{ins(1, 1, 2, 1, 9, 1, 0), z(1)};
    v[27] = '{ins(0, 1, 0, 0, 0, 0, 0), z(1)};
    v[28] = '{ins(0, 1, 0, 0, 0, 0, 0), z(1)};
    v[29] = '{ins(9, 1, 13, 1, 12, 1, 0), ex(0, 0, 0, 2'b00, 2'b00, 1, 0, 1)};
    v[30] = '{ins(1, 1, 2, 1, 9, 0, 0), z(1)};
    v[31] = '{ins(0, 1, 0, 0, 0, 0, 0), z(1)};
    v[32] = '{ins(0, 1, 0, 0, 0, 0, 0), z(1)};
    v[33] = '{ins(9, 1, 12, 1, 0, 0, 0), z(1)};
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(in_t'($urandom));
      id_valid = 1;
      #1 check($sformatf("reset%0d", k), z(0));
    end
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < NV; k++) begin
      if (k > 0) @(negedge clk);
      drive(v[k].i);
      #1 check($sformatf("vec%0d", k), v[k].o);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive('0);
    end
    @(negedge clk);
    drive(ins(1, 1, 0, 0, 2, 1, 1));
    @(negedge clk);
    drive(ins(2, 1, 0, 0, 3, 1, 0));
    #1 check("midstall_pre", ex(1, 0, 1, 2'b00, 2'b00, 0, 0, 1));
    rst = 1;
    #1 check("midstall_rst", z(0));
    @(negedge clk);
    rst = 0;
    #1 check("midstall_post", z(0));
    @(negedge clk);
    drive('0);
    #1 check("midstall_idle", z(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
